// File: rtl/rnn_frame_seq_if.sv
// rnn_frame_seq_if: frame input, stage handshake and result signals of the RNN frame sequencer
interface rnn_frame_seq_if #(
  parameter int FLOAT = 32,
  parameter int FEATURE_SIZE = 42,
  parameter int OUT_SIZE = 22,
  parameter int NUM_STAGES = 6,
  parameter int CNT_W = 16
);
  logic in_valid, in_ready, state_clear, frame_clear, out_valid, out_ready, err_timeout;
  logic [FEATURE_SIZE*FLOAT-1:0] in_feature, feature_q;
  logic [NUM_STAGES-1:0] stage_start, stage_done;
  logic [OUT_SIZE*FLOAT-1:0] gains_in, out_gains;
  logic [FLOAT-1:0] vad_in, out_vad;
  logic [CNT_W-1:0] frame_count, drop_count;
  modport master (
    input in_valid, in_feature, state_clear, stage_done, gains_in, vad_in, out_ready,
    output in_ready, feature_q, frame_clear, stage_start, out_valid, out_gains, out_vad,
    frame_count, drop_count, err_timeout
  );
  modport slave (
    output in_valid, in_feature, state_clear, stage_done, gains_in, vad_in, out_ready,
    input in_ready, feature_q, frame_clear, stage_start, out_valid, out_gains, out_vad,
    frame_count, drop_count, err_timeout
  );
endinterface

// File: rtl/rnn_frame_seq.sv
// rnn_frame_seq: accepts a feature frame, runs the compute stages in order, and delivers gains/VAD
module rnn_frame_seq #(
  parameter int FLOAT = 32,
  parameter int FEATURE_SIZE = 42,
  parameter int OUT_SIZE = 22,
  parameter int NUM_STAGES = 6,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  rnn_frame_seq_if.master bus
);
  localparam int KW = $clog2(NUM_STAGES);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k;
  logic [TW-1:0] wcnt;
  logic clear_pending, accept, done_k, last, expire;
  assign accept = state == IDLE && bus.in_valid;
  assign done_k = |(bus.stage_done & (NUM_STAGES'(1) << k));
  assign last = k == KW'(NUM_STAGES - 1);
  assign expire = wcnt == TW'(TIMEOUT - 1);
  // next state and handshake outputs; a done on the expiry cycle takes priority over the timeout
  always_comb begin
    state_nx = state;
    bus.in_ready = state == IDLE;
    bus.out_valid = state == OUT;
    bus.stage_start = state == START ? NUM_STAGES'(1) << k : '0;
    state_nx = state == IDLE ? (bus.in_valid ? START : IDLE) :
               state == START ? WAIT :
               state == WAIT ? (done_k ? (last ? OUT : START) : (expire ? IDLE : WAIT)) :
               (bus.out_ready ? IDLE : OUT);
  end
  // state, frame latch, stage index, wait counter, result capture and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      wcnt <= '0;
      clear_pending <= 1'b0;
      bus.frame_clear <= 1'b0;
      bus.feature_q <= '0;
      bus.out_gains <= '0;
      bus.out_vad <= '0;
      bus.frame_count <= '0;
      bus.drop_count <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      clear_pending <= accept ? 1'b0 : clear_pending | bus.state_clear;
      if (accept) begin
        bus.feature_q <= bus.in_feature;
        bus.frame_clear <= clear_pending | bus.state_clear;
        k <= '0;
      end
      if (state == START) wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + TW'(1);
      if (state == WAIT && done_k && !last) k <= k + KW'(1);
      if (state == WAIT && done_k && last) begin
        bus.out_gains <= bus.gains_in;
        bus.out_vad <= bus.vad_in;
      end
      if (state == WAIT && !done_k && expire) begin
        bus.err_timeout <= 1'b1;
        bus.drop_count <= bus.drop_count + CNT_W'(1);
      end
      if (state == OUT && bus.out_ready) bus.frame_count <= bus.frame_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rnn_frame_seq.sv
// tb_rnn_frame_seq: directed frame sequences with hand-computed expectations
module tb_rnn_frame_seq;
  localparam int FL = 32, FS = 42, OS = 22, NS = 6, TO = 8, CW = 16;
  localparam int FW = FS * FL;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_err = 0;
  int dly[NS];
  bit to;
  always #5 clk = ~clk;
  rnn_frame_seq_if #(.FLOAT(FL), .FEATURE_SIZE(FS), .OUT_SIZE(OS), .NUM_STAGES(NS), .CNT_W(CW)) bus ();
  rnn_frame_seq #(.FLOAT(FL), .FEATURE_SIZE(FS), .OUT_SIZE(OS), .NUM_STAGES(NS), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  function automatic logic [FW-1:0] fpat(input int n);
    return {FS{32'(n) * 32'h0101_0101}};
  endfunction
  function automatic logic [OS*FL-1:0] gpat(input int n);
    return {OS{32'(n) * 32'h1357_9bdf}};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_stage_start", bus.stage_start, 0);
    chk("rst_feature_q", bus.feature_q, 0);
    chk("rst_frame_clear", bus.frame_clear, 0);
    chk("rst_out_gains", bus.out_gains, 0);
    chk("rst_out_vad", bus.out_vad, 0);
    chk("rst_frame_count", bus.frame_count, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);
  endtask
  task automatic send(input logic [FW-1:0] f, input logic clr, input logic fc_exp);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_feature = f;
    bus.state_clear = clr;
    tick;
    bus.in_valid = 1'b0;
    bus.state_clear = 1'b0;
    bus.in_feature = ~f;
    chk("feature_q", bus.feature_q, f);
    chk("frame_clear", bus.frame_clear, fc_exp);
    chk("in_ready_busy", bus.in_ready, 0);
  endtask
  task automatic run_stages(input int n, input int clr_k, input bit noise, output bit timed_out);
    logic [NS-1:0] b;
    timed_out = 1'b0;
    for (int k = 0; k < n; k++) begin
      b = NS'(1) << k;
      chk($sformatf("start%0d", k), bus.stage_start, b);
      tick;
      chk($sformatf("start_once%0d", k), bus.stage_start, 0);
      bus.stage_done = noise ? ~b : '0;
      if (k == clr_k) bus.state_clear = 1'b1;
      if (dly[k] == 0) begin
        repeat (TO - 1) tick;
        chk("to_not_yet", bus.in_ready, 0);
        tick;
        bus.stage_done = '0;
        bus.state_clear = 1'b0;
        timed_out = 1'b1;
        return;
      end
      repeat (dly[k] - 1) tick;
      bus.stage_done = b;
      if (k == NS - 1) chk("valid_early", bus.out_valid, 0);
      tick;
      bus.stage_done = '0;
      bus.state_clear = 1'b0;
    end
    if (n == NS) chk("out_valid", bus.out_valid, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_feature = '0;
    bus.state_clear = 1'b0;
    bus.stage_done = '0;
    bus.gains_in = '0;
    bus.vad_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    chk_reset;
    // frame A: every stage done 3 cycles after its start, out_valid 24 edges after accept
    bus.out_ready = 1'b1;
    bus.gains_in = gpat(1);
    bus.vad_in = 32'hA1;
    dly = '{3, 3, 3, 3, 3, 3};
    send(fpat(1), 1'b0, 1'b0);
    run_stages(NS, -1, 1'b0, to);
    bus.gains_in = gpat(9);
    bus.vad_in = 32'h99;
    chk("A_gains", bus.out_gains, gpat(1));
    chk("A_vad", bus.out_vad, 32'hA1);
    chk("A_fc_before", bus.frame_count, 0);
    tick;
    chk("A_fc", bus.frame_count, 1);
    chk("A_ready", bus.in_ready, 1);
    chk("A_valid_low", bus.out_valid, 0);
    // frame B: minimum latency, stray done bits, clear request in WAIT, output backpressure
    bus.out_ready = 1'b0;
    bus.gains_in = gpat(2);
    bus.vad_in = 32'hB2;
    dly = '{1, 1, 1, 1, 1, 1};
    send(fpat(2), 1'b0, 1'b0);
    run_stages(NS, 2, 1'b1, to);
    bus.gains_in = gpat(9);
    bus.vad_in = 32'h99;
    for (int i = 0; i < 10; i++) begin
      chk("B_hold_valid", bus.out_valid, 1);
      chk("B_hold_gains", bus.out_gains, gpat(2));
      chk("B_hold_vad", bus.out_vad, 32'hB2);
      chk("B_hold_ready", bus.in_ready, 0);
      tick;
    end
    chk("B_fc_before", bus.frame_count, 1);
    bus.out_ready = 1'b1;
    tick;
    chk("B_fc", bus.frame_count, 2);
    chk("B_ready", bus.in_ready, 1);
    // frame C: pending clear applies; stage 1 done exactly at the timeout boundary
    bus.gains_in = gpat(3);
    bus.vad_in = 32'hC3;
    dly = '{1, 8, 1, 1, 1, 1};
    send(fpat(3), 1'b0, 1'b1);
    run_stages(NS, -1, 1'b0, to);
    chk("C_err", bus.err_timeout, 0);
    chk("C_drop", bus.drop_count, 0);
    chk("C_gains", bus.out_gains, gpat(3));
    tick;
    chk("C_fc", bus.frame_count, 3);
    // frame D: clear consumed, stage 2 never completes
    bus.gains_in = gpat(4);
    bus.vad_in = 32'hD4;
    dly = '{1, 1, 0, 1, 1, 1};
    send(fpat(4), 1'b0, 1'b0);
    run_stages(NS, -1, 1'b0, to);
    chk("D_err", bus.err_timeout, 1);
    chk("D_drop", bus.drop_count, 1);
    chk("D_ready", bus.in_ready, 1);
    chk("D_valid", bus.out_valid, 0);
    chk("D_start", bus.stage_start, 0);
    chk("D_gains_kept", bus.out_gains, gpat(3));
    chk("D_vad_kept", bus.out_vad, 32'hC3);
    chk("D_fc", bus.frame_count, 3);
    // frame E: clear on the accept cycle, normal completion after a drop
    bus.gains_in = gpat(5);
    bus.vad_in = 32'hE5;
    dly = '{2, 2, 2, 2, 2, 2};
    send(fpat(5), 1'b1, 1'b1);
    run_stages(NS, -1, 1'b0, to);
    chk("E_gains", bus.out_gains, gpat(5));
    chk("E_err_sticky", bus.err_timeout, 1);
    tick;
    chk("E_fc", bus.frame_count, 4);
    chk("E_drop", bus.drop_count, 1);
    // frame F: no pending clear left over, reset during WAIT of stage 3
    dly = '{1, 1, 1, 1, 1, 1};
    send(fpat(6), 1'b0, 1'b0);
    run_stages(3, -1, 1'b0, to);
    chk("F_start3", bus.stage_start, 6'b001000);
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk_reset;
    bus.stage_done = 6'b001000;
    tick;
    bus.stage_done = '0;
    chk("F_stray_start", bus.stage_start, 0);
    chk("F_stray_ready", bus.in_ready, 1);
    // frame G: fresh frame after reset starts at stage 0
    bus.gains_in = gpat(7);
    bus.vad_in = 32'h77;
    send(fpat(7), 1'b0, 1'b0);
    run_stages(NS, -1, 1'b0, to);
    chk("G_gains", bus.out_gains, gpat(7));
    tick;
    chk("G_fc", bus.frame_count, 1);
    chk("G_err", bus.err_timeout, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
